// File: rtl/add_rs_pkg.sv
// Shared types for the add/sub/branch reservation station: CDB packet, RS entry, branch encodings.
package add_rs_pkg;

  localparam int unsigned ROB_TAG_W = 4;
  localparam int unsigned XLEN      = 32;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BNE  = 2'b01,
    BR_BEQ  = 2'b10,
    BR_BLT  = 2'b11
  } branch_type_e;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] dest_ROB_entry;
    logic [XLEN-1:0]      result;
    logic                 load_step1;
  } CDB_packet_t;

  typedef struct packed {
    logic [XLEN-1:0]      val;
    logic [ROB_TAG_W-1:0] tag;
    logic                 rdy;
  } add_rs_opnd_t;

  typedef struct packed {
    logic                 aluop;
    logic                 load;
    branch_type_e         branch_type;
    logic [ROB_TAG_W-1:0] rob;
    add_rs_opnd_t         rs1;
    add_rs_opnd_t         rs2;
  } add_rs_entry_t;

endpackage

// File: rtl/add_rs_wakeup.sv
// One operand's CDB tag compare and value/rdy update; shared by stored entries and dispatch capture.
module add_rs_wakeup
  import add_rs_pkg::*;
(
  input  logic         enable,
  input  add_rs_opnd_t opnd,
  input  logic         cdb_valid,
  input  CDB_packet_t  cdb_in,
  output add_rs_opnd_t opnd_nxt_c
);

  logic hit;

  // load_step1 packets carry addresses and must never wake an operand
  always_comb begin
    hit        = enable & ~opnd.rdy & cdb_valid & ~cdb_in.load_step1
                 & (opnd.tag == cdb_in.dest_ROB_entry);
    opnd_nxt_c = opnd;
    if (hit) begin
      opnd_nxt_c.val = cdb_in.result;
      opnd_nxt_c.rdy = 1'b1;
    end
  end

endmodule

// File: rtl/add_rs.sv
// Reservation station for the adder FU: age-ordered collapsing queue, CDB wakeup, oldest-ready issue.
// Optional macro ADD_RS_ISSUE_BYPASS_EN: select and issue straight from the current CDB broadcast.
module add_rs
  import add_rs_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = ROB_TAG_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic                       disp_aluop,
  input  logic                       disp_load,
  input  logic [1:0]                 disp_branch_type,
  input  logic [TAG_W-1:0]           disp_rob,
  input  logic [31:0]                disp_rs1_val,
  input  logic [31:0]                disp_rs2_val,
  input  logic [TAG_W-1:0]           disp_rs1_tag,
  input  logic [TAG_W-1:0]           disp_rs2_tag,
  input  logic                       disp_rs1_rdy,
  input  logic                       disp_rs2_rdy,
  input  logic                       cdb_valid,
  input  CDB_packet_t                cdb_in,
  input  logic                       fu_ready,
  output logic                       issue_valid,
  output logic [31:0]                issue_rs1,
  output logic [31:0]                issue_rs2,
  output logic                       issue_aluop,
  output logic                       issue_load,
  output logic [1:0]                 issue_branch_type,
  output logic [TAG_W-1:0]           issue_rob,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  add_rs_entry_t ent_q   [DEPTH];
  add_rs_entry_t ent_upd [DEPTH];
  add_rs_entry_t ent_up1 [DEPTH];
  add_rs_entry_t sel_src [DEPTH];
  add_rs_entry_t ent_d   [DEPTH];
  add_rs_opnd_t  upd_rs1 [DEPTH];
  add_rs_opnd_t  upd_rs2 [DEPTH];

  logic [DEPTH-1:0] ent_valid;
  add_rs_entry_t    disp_raw;
  add_rs_entry_t    disp_cap;
  add_rs_opnd_t     cap_rs1;
  add_rs_opnd_t     cap_rs2;
  add_rs_entry_t    cand_ent;
  logic             cand_found;
  logic [IDX_W-1:0] cand_idx;
  logic             disp_fire;
  logic [OCC_W-1:0] occ_after;
  logic [OCC_W-1:0] occ_d;

  assign disp_ready = (occupancy < OCC_W'(DEPTH));
  assign disp_fire  = disp_valid & disp_ready;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = (OCC_W'(i) < occupancy);
    end
  end

  // Per-entry operand wakeup plus the one-position-down view used when an older entry issues
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    add_rs_wakeup u_wk_rs1 (
      .enable     (ent_valid[g]),
      .opnd       (ent_q[g].rs1),
      .cdb_valid  (cdb_valid),
      .cdb_in     (cdb_in),
      .opnd_nxt_c (upd_rs1[g])
    );
    add_rs_wakeup u_wk_rs2 (
      .enable     (ent_valid[g]),
      .opnd       (ent_q[g].rs2),
      .cdb_valid  (cdb_valid),
      .cdb_in     (cdb_in),
      .opnd_nxt_c (upd_rs2[g])
    );
    if (g < DEPTH - 1) begin : g_shift
      assign ent_up1[g] = ent_upd[g+1];
    end else begin : g_top
      assign ent_up1[g] = ent_upd[g];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_upd[i]     = ent_q[i];
      ent_upd[i].rs1 = upd_rs1[i];
      ent_upd[i].rs2 = upd_rs2[i];
`ifdef ADD_RS_ISSUE_BYPASS_EN
      sel_src[i]     = ent_upd[i];
`else
      sel_src[i]     = ent_q[i];
`endif
    end
  end

  always_comb begin
    disp_raw             = '0;
    disp_raw.aluop       = disp_aluop;
    disp_raw.load        = disp_load;
    disp_raw.branch_type = branch_type_e'(disp_branch_type);
    disp_raw.rob         = ROB_TAG_W'(disp_rob);
    disp_raw.rs1         = '{val: disp_rs1_val, tag: ROB_TAG_W'(disp_rs1_tag), rdy: disp_rs1_rdy};
    disp_raw.rs2         = '{val: disp_rs2_val, tag: ROB_TAG_W'(disp_rs2_tag), rdy: disp_rs2_rdy};
    disp_cap             = disp_raw;
    disp_cap.rs1         = cap_rs1;
    disp_cap.rs2         = cap_rs2;
  end

  add_rs_wakeup u_cap_rs1 (
    .enable     (1'b1),
    .opnd       (disp_raw.rs1),
    .cdb_valid  (cdb_valid),
    .cdb_in     (cdb_in),
    .opnd_nxt_c (cap_rs1)
  );
  add_rs_wakeup u_cap_rs2 (
    .enable     (1'b1),
    .opnd       (disp_raw.rs2),
    .cdb_valid  (cdb_valid),
    .cdb_in     (cdb_in),
    .opnd_nxt_c (cap_rs2)
  );

  // Oldest-first select: lowest valid index with both operands ready
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    cand_ent   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!cand_found && ent_valid[i] && sel_src[i].rs1.rdy && sel_src[i].rs2.rdy) begin
        cand_found = 1'b1;
        cand_idx   = IDX_W'(i);
        cand_ent   = sel_src[i];
      end
    end
  end

  always_comb begin
    issue_valid       = fu_ready & cand_found;
    issue_rs1         = '0;
    issue_rs2         = '0;
    issue_aluop       = 1'b0;
    issue_load        = 1'b0;
    issue_branch_type = BR_NONE;
    issue_rob         = '0;
    if (issue_valid) begin
      issue_rs1         = cand_ent.rs1.val;
      issue_rs2         = cand_ent.rs2.val;
      issue_aluop       = cand_ent.aluop;
      issue_load        = cand_ent.load;
      issue_branch_type = cand_ent.branch_type;
      issue_rob         = TAG_W'(cand_ent.rob);
    end
  end

  // Collapse over the issued slot, then append the dispatch at the new tail
  always_comb begin
    occ_after = occupancy - OCC_W'(issue_valid);
    occ_d     = occ_after + OCC_W'(disp_fire);
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_upd[i];
      if (issue_valid && (IDX_W'(i) >= cand_idx)) begin
        ent_d[i] = ent_up1[i];
      end
      if (disp_fire && (OCC_W'(i) == occ_after)) begin
        ent_d[i] = disp_cap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      occupancy <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

endmodule

// File: tb/tb_add_rs.sv
// Self-checking bench for add_rs: queue-based reference model, directed scenarios, then random traffic.
module tb_add_rs;
  import add_rs_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;

  logic              clk = 1'b0;
  logic              reset, flush;
  logic              disp_valid, disp_ready, disp_aluop, disp_load;
  logic [1:0]        disp_branch_type;
  logic [TAG_W-1:0]  disp_rob, disp_rs1_tag, disp_rs2_tag;
  logic [31:0]       disp_rs1_val, disp_rs2_val;
  logic              disp_rs1_rdy, disp_rs2_rdy;
  logic              cdb_valid;
  CDB_packet_t       cdb_in;
  logic              fu_ready;
  logic              issue_valid, issue_aluop, issue_load;
  logic [31:0]       issue_rs1, issue_rs2;
  logic [1:0]        issue_branch_type;
  logic [TAG_W-1:0]  issue_rob;
  logic [2:0]        occupancy;

  add_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_aluop(disp_aluop), .disp_load(disp_load), .disp_branch_type(disp_branch_type),
    .disp_rob(disp_rob),
    .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .cdb_valid(cdb_valid), .cdb_in(cdb_in), .fu_ready(fu_ready),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_aluop(issue_aluop), .issue_load(issue_load),
    .issue_branch_type(issue_branch_type), .issue_rob(issue_rob),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        aluop;
    logic        load;
    logic [1:0]  bt;
    logic [3:0]  rob;
    logic [31:0] v1, v2;
    logic [3:0]  t1, t2;
    logic        r1, r2;
  } m_ent_t;

  m_ent_t q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  logic   exp_iv;
  int     exp_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic cdb_q();
    return cdb_valid && !cdb_in.load_step1;
  endfunction

  task automatic idle();
    reset = 0; flush = 0; disp_valid = 0; disp_aluop = 0; disp_load = 0;
    disp_branch_type = 0; disp_rob = 0; disp_rs1_val = 0; disp_rs2_val = 0;
    disp_rs1_tag = 0; disp_rs2_tag = 0; disp_rs1_rdy = 0; disp_rs2_rdy = 0;
    cdb_valid = 0; cdb_in = '0;
  endtask

  task automatic disp(input logic [3:0] rob, input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                      input logic r2, input logic [31:0] v2, input logic [3:0] t2);
    disp_valid = 1; disp_rob = rob;
    disp_rs1_rdy = r1; disp_rs1_val = v1; disp_rs1_tag = t1;
    disp_rs2_rdy = r2; disp_rs2_val = v2; disp_rs2_tag = t2;
  endtask

  task automatic cdb(input logic [3:0] dest, input logic [31:0] res, input logic ls1);
    cdb_valid = 1; cdb_in.dest_ROB_entry = dest; cdb_in.result = res; cdb_in.load_step1 = ls1;
  endtask

  // Compare all DUT outputs against the model for the current state and inputs
  task automatic compare();
    m_ent_t sel;
    logic   found;
    #1;
    found = 0; exp_idx = 0; sel = '{default: '0};
    foreach (q[i]) begin
      m_ent_t e;
      e = q[i];
`ifdef ADD_RS_ISSUE_BYPASS_EN
      if (!e.r1 && cdb_q() && e.t1 == cdb_in.dest_ROB_entry) begin e.r1 = 1; e.v1 = cdb_in.result; end
      if (!e.r2 && cdb_q() && e.t2 == cdb_in.dest_ROB_entry) begin e.r2 = 1; e.v2 = cdb_in.result; end
`endif
      if (!found && e.r1 && e.r2) begin found = 1; exp_idx = i; sel = e; end
    end
    exp_iv = fu_ready && found;
    check("occupancy", 32'(occupancy), 32'(q.size()));
    check("disp_ready", 32'(disp_ready), 32'(q.size() < DEPTH));
    check("issue_valid", 32'(issue_valid), 32'(exp_iv));
    if (exp_iv) begin
      check("issue_rob", 32'(issue_rob), 32'(sel.rob));
      check("issue_rs1", issue_rs1, sel.v1);
      check("issue_rs2", issue_rs2, sel.v2);
      check("issue_aluop", 32'(issue_aluop), 32'(sel.aluop));
      check("issue_load", 32'(issue_load), 32'(sel.load));
      check("issue_branch_type", 32'(issue_branch_type), 32'(sel.bt));
    end
  endtask

  // Apply the clock edge to the model, then move to the next sampling point
  task automatic advance();
    int pre;
    pre = q.size();
    if (reset || flush) begin
      q.delete();
    end else begin
      if (exp_iv) q.delete(exp_idx);
      foreach (q[i]) begin
        if (!q[i].r1 && cdb_q() && q[i].t1 == cdb_in.dest_ROB_entry) begin q[i].r1 = 1; q[i].v1 = cdb_in.result; end
        if (!q[i].r2 && cdb_q() && q[i].t2 == cdb_in.dest_ROB_entry) begin q[i].r2 = 1; q[i].v2 = cdb_in.result; end
      end
      if (disp_valid && pre < DEPTH) begin
        m_ent_t n;
        n.aluop = disp_aluop; n.load = disp_load; n.bt = disp_branch_type; n.rob = disp_rob;
        n.v1 = disp_rs1_val; n.t1 = disp_rs1_tag; n.r1 = disp_rs1_rdy;
        n.v2 = disp_rs2_val; n.t2 = disp_rs2_tag; n.r2 = disp_rs2_rdy;
        if (!n.r1 && cdb_q() && n.t1 == cdb_in.dest_ROB_entry) begin n.r1 = 1; n.v1 = cdb_in.result; end
        if (!n.r2 && cdb_q() && n.t2 == cdb_in.dest_ROB_entry) begin n.r2 = 1; n.v2 = cdb_in.result; end
        q.push_back(n);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc();
    compare();
    advance();
  endtask

  initial begin
    idle();
    reset = 1; fu_ready = 1;
    @(posedge clk); @(negedge clk);
    compare();
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_disp_ready", 32'(disp_ready), 32'd1);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_issue_rs1", issue_rs1, 32'd0);
    check("rst_issue_rob", 32'(issue_rob), 32'd0);
    advance();
    idle();

    // Both operands ready at dispatch: issue one cycle later
    disp(3, 1, 5, 0, 1, 7, 0); cyc();
    idle(); compare();
    check("t1_issue_valid", 32'(issue_valid), 32'd1);
    check("t1_issue_rs1", issue_rs1, 32'd5);
    check("t1_issue_rs2", issue_rs2, 32'd7);
    check("t1_issue_rob", 32'(issue_rob), 32'd3);
    advance();
    compare(); check("t1_occ_zero", 32'(occupancy), 32'd0); advance();

    // CDB wakeup of rs2, then the same with a load_step1 packet
    disp(2, 1, 1, 0, 0, 0, 9); cyc();
    idle(); cyc();
    cdb(9, 32'h10, 0); compare();
`ifndef ADD_RS_ISSUE_BYPASS_EN
    check("t2_no_same_cycle", 32'(issue_valid), 32'd0);
`endif
    advance();
    idle(); compare();
`ifndef ADD_RS_ISSUE_BYPASS_EN
    check("t2_issue_valid", 32'(issue_valid), 32'd1);
    check("t2_issue_rs2", issue_rs2, 32'h10);
    check("t2_issue_rob", 32'(issue_rob), 32'd2);
`endif
    advance();
    disp(2, 1, 1, 0, 0, 0, 9); cyc();
    idle(); cyc();
    cdb(9, 32'h10, 1); cyc();
    idle(); compare(); check("t2_ls1_no_wake", 32'(issue_valid), 32'd0); advance();
    flush = 1; cyc(); idle();

    // Younger ready entry bypasses an older waiting one
    disp(1, 0, 0, 5, 1, 3, 0); cyc();
    disp(4, 1, 8, 0, 1, 9, 0); cyc();
    idle(); compare();
    check("t3_young_first", 32'(issue_rob), 32'd4);
    check("t3_occ2", 32'(occupancy), 32'd2);
    advance();
    cdb(5, 32'h55, 0); cyc();
    idle(); compare();
    check("t3_old_rob", 32'(issue_rob), 32'd1);
    check("t3_old_rs1", issue_rs1, 32'h55);
    check("t3_old_rs2", issue_rs2, 32'd3);
    advance();
    cyc();

    // Fill, blocked dispatch, then drain
    fu_ready = 0;
    for (int i = 0; i < 4; i++) begin
      disp(4'(10 + i), 1, 32'(100 + i), 0, 1, 32'(200 + i), 0); cyc();
    end
    disp(14, 1, 1, 0, 1, 2, 0); compare();
    check("t4_full_rdy", 32'(disp_ready), 32'd0);
    check("t4_full_occ", 32'(occupancy), 32'd4);
    advance();
    fu_ready = 1; compare();
    check("t4_issue_oldest", 32'(issue_rob), 32'd10);
    check("t4_blocked", 32'(disp_ready), 32'd0);
    advance();
    idle(); compare();
    check("t4_after_rdy", 32'(disp_ready), 32'd1);
    check("t4_after_occ", 32'(occupancy), 32'd3);
    advance();
    for (int i = 0; i < 4; i++) cyc();

    // Flush overrides a same-cycle dispatch
    fu_ready = 0;
    for (int i = 0; i < 3; i++) begin
      disp(4'(i), 0, 0, 15, 1, 1, 0); cyc();
    end
    disp(6, 1, 1, 0, 1, 1, 0); flush = 1; compare();
    check("t5_occ3", 32'(occupancy), 32'd3);
    advance();
    idle(); fu_ready = 1; compare();
    check("t5_flush_occ", 32'(occupancy), 32'd0);
    check("t5_flush_iv", 32'(issue_valid), 32'd0);
    advance();

`ifdef ADD_RS_ISSUE_BYPASS_EN
    disp(7, 0, 0, 4, 1, 1, 0); cyc();
    idle(); cdb(4, 32'h20, 0); compare();
    check("t6_bypass_iv", 32'(issue_valid), 32'd1);
    check("t6_bypass_rs1", issue_rs1, 32'h20);
    advance();
    idle(); cyc();
`endif

    // Randomized traffic with a small tag space so wakeups are frequent
    for (int n = 0; n < 3000; n++) begin
      idle();
      reset = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 99) == 0);
      fu_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 9) < 7) begin
        disp(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 3)));
        disp_aluop = 1'($urandom_range(0, 1));
        disp_load = 1'($urandom_range(0, 1));
        disp_branch_type = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 1) == 1) cdb(4'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 4) == 0));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
